// File: rtl/elevator_scan_ctrl_if.sv
// Floor-request handshake between a requester (master) and the car controller (slave).
interface elevator_scan_ctrl_if #(
  parameter int FW = 4
);
  logic          valid_in;
  logic [FW-1:0] floor_in;
  logic          ready_out;

  modport master (output valid_in, floor_in, input  ready_out);
  modport slave  (input  valid_in, floor_in, output ready_out);
endinterface

// File: rtl/elevator_scan_ctrl.sv
// SCAN elevator controller for one car: pending-floor bitmap, travel/dwell timing,
// and direction reversal only when nothing remains ahead.
module elevator_scan_ctrl #(
  parameter  int NUM_FLOORS  = 16,
  parameter  int MAX_REQ     = 4,
  parameter  int FLOOR_TICKS = 4,
  parameter  int DOOR_TICKS  = 8,
  localparam int FW          = $clog2(NUM_FLOORS),
  localparam int CW          = $clog2(NUM_FLOORS + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  elevator_scan_ctrl_if.slave   req,
  output logic [FW-1:0]         current_floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic                  stop_pulse,
  output logic                  req_err,
  output logic [NUM_FLOORS-1:0] pending_map,
  output logic [CW-1:0]         pending_count
);

  localparam int TMAX = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_DN   = 2'd2;
  localparam logic [1:0] S_DOOR = 2'd3;

  logic [1:0]            state, state_nxt;
  logic [TW-1:0]         timer, timer_nxt;
  logic [FW-1:0]         cur, cur_nxt, step;
  logic                  dir, dir_nxt;
  logic [NUM_FLOORS-1:0] pend, pend_nxt, pend_acc, set_mask, clr_mask;
  logic [NUM_FLOORS-1:0] req_oh, cur_oh, step_oh;
  logic [CW-1:0]         cnt;
  logic                  acc, oor, restart;
  logic                  above, below, ahead;

  function automatic logic [CW-1:0] popcnt(input logic [NUM_FLOORS-1:0] v);
    popcnt = '0;
    for (int i = 0; i < NUM_FLOORS; i++) popcnt = popcnt + CW'(v[i]);
  endfunction

  assign req.ready_out = (cnt < CW'(MAX_REQ));
  assign acc           = req.valid_in && req.ready_out;
  assign step          = (state == S_DN) ? cur - 1'b1 : cur + 1'b1;

  always_comb begin
    req_oh  = '0;
    cur_oh  = '0;
    step_oh = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      req_oh[i]  = (int'(req.floor_in) == i);
      cur_oh[i]  = (int'(cur) == i);
      step_oh[i] = (int'(step) == i);
    end
  end

  // A request for the floor whose door is open only extends the dwell.
  assign oor      = ~|req_oh;
  assign restart  = acc && (state == S_DOOR) && |(req_oh & cur_oh);
  assign set_mask = (acc && !restart) ? req_oh : '0;
  assign pend_acc = pend | set_mask;

  // above/below look at registered state; "ahead" after a step also sees this cycle's accept.
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    ahead = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i > int'(cur)) above = above | pend[i];
      if (i < int'(cur)) below = below | pend[i];
      if (state == S_DN) begin
        if (i < int'(step)) ahead = ahead | pend_acc[i];
      end else begin
        if (i > int'(step)) ahead = ahead | pend_acc[i];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    cur_nxt   = cur;
    dir_nxt   = dir;
    clr_mask  = '0;
    case (state)
      S_IDLE: begin
        timer_nxt = '0;
        if (|(pend & cur_oh)) begin
          state_nxt = S_DOOR;
          clr_mask  = cur_oh;
        end else if (above && below) begin
          state_nxt = dir ? S_UP : S_DN;
        end else if (above) begin
          state_nxt = S_UP;
          dir_nxt   = 1'b1;
        end else if (below) begin
          state_nxt = S_DN;
          dir_nxt   = 1'b0;
        end
      end
      S_UP, S_DN: begin
        if (timer == TW'(FLOOR_TICKS - 1)) begin
          timer_nxt = '0;
          cur_nxt   = step;
          if (|(pend_acc & step_oh)) begin
            state_nxt = S_DOOR;
            clr_mask  = step_oh;
          end else if (!ahead) begin
            state_nxt = S_IDLE;
          end
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      default: begin
        if (restart) begin
          timer_nxt = '0;
        end else if (timer == TW'(DOOR_TICKS - 1)) begin
          timer_nxt = '0;
          if (dir && above) begin
            state_nxt = S_UP;
          end else if (below) begin
            state_nxt = S_DN;
            dir_nxt   = 1'b0;
          end else if (above) begin
            state_nxt = S_UP;
            dir_nxt   = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
    endcase
    // Clearing the floor being served wins over a same-cycle accept for it.
    pend_nxt = pend_acc & ~clr_mask;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      timer      <= '0;
      cur        <= '0;
      dir        <= 1'b1;
      pend       <= '0;
      cnt        <= '0;
      stop_pulse <= 1'b0;
      req_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      cur        <= cur_nxt;
      dir        <= dir_nxt;
      pend       <= pend_nxt;
      cnt        <= popcnt(pend_nxt);
      stop_pulse <= (state_nxt == S_DOOR) && (state != S_DOOR);
      req_err    <= acc && oor;
    end
  end

  assign current_floor = cur;
  assign dir_up        = dir;
  assign moving        = (state == S_UP) || (state == S_DN);
  assign door_open     = (state == S_DOOR);
  assign pending_map   = pend;
  assign pending_count = cnt;

endmodule
